// File: rtl/wireframe_fb.sv
`timescale 1ns/1ps
// wireframe_fb: 1-bit-per-pixel wireframe frame buffer behind the rasterizer.
// Absorbs rasterizer pixel writes, clears the frame one row per cycle, and
// streams the frame out in raster order over a valid/ready handshake.
//
// Ports:
//   clk, n_rst      - clock (rising edge), asynchronous active-low reset
//   write_en/wf_data/addr - rasterizer pixel write (addr = y*WIDTH+x)
//   clear_start     - one-cycle request to clear the whole frame
//   scan_start      - one-cycle request to stream the frame out
//   pix_ready       - downstream accepts the current pixel
//   pix_valid/pix_data/pix_x/pix_y/pix_eol/pix_eof - scan-out beat
//   clear_done      - one-cycle pulse when a clear completes
//   busy            - high while clearing or scanning
//   wr_drop         - one-cycle pulse when a write was discarded
module wireframe_fb #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned HEIGHT    = 48,
  parameter int unsigned ADDR_SIZE = 12,
  parameter logic        CLEAR_VAL = 1'b1
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        write_en,
  input  logic                        wf_data,
  input  logic [ADDR_SIZE-1:0]        addr,
  input  logic                        clear_start,
  input  logic                        scan_start,
  input  logic                        pix_ready,
  output logic                        pix_valid,
  output logic                        pix_data,
  output logic [$clog2(WIDTH)-1:0]    pix_x,
  output logic [$clog2(HEIGHT)-1:0]   pix_y,
  output logic                        pix_eol,
  output logic                        pix_eof,
  output logic                        clear_done,
  output logic                        busy,
  output logic                        wr_drop
);

  localparam int unsigned X_W  = $clog2(WIDTH);
  localparam int unsigned Y_W  = $clog2(HEIGHT);
  localparam int unsigned NPIX = WIDTH * HEIGHT;

  localparam logic [X_W-1:0]       LAST_X   = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]       LAST_Y   = Y_W'(HEIGHT - 1);
  // One extra bit so a frame filling the whole address space still compares correctly.
  localparam logic [ADDR_SIZE:0]   NPIX_EXT = (ADDR_SIZE + 1)'(NPIX);
  localparam logic [ADDR_SIZE-1:0] WIDTH_A  = ADDR_SIZE'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SCAN  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [NPIX-1:0]      r_mem;
  logic [Y_W-1:0]       r_row;
  logic [X_W-1:0]       r_pix_x;
  logic [Y_W-1:0]       r_pix_y;
  logic                 r_pix_valid;
  logic                 r_clear_done;
  logic                 r_busy;
  logic                 r_wr_drop;

  logic                 w_accept;
  logic                 w_eol;
  logic                 w_eof;
  logic                 w_addr_ok;
  logic                 w_wr_en;
  logic [ADDR_SIZE-1:0] w_rd_addr;
  logic [ADDR_SIZE-1:0] w_clr_base;

  // Beat qualifiers and address arithmetic, all at ADDR_SIZE bits.
  assign w_eol      = (r_pix_x == LAST_X);
  assign w_eof      = w_eol && (r_pix_y == LAST_Y);
  assign w_accept   = r_pix_valid && pix_ready;
  assign w_addr_ok  = ({1'b0, addr} < NPIX_EXT);
  assign w_wr_en    = write_en && w_addr_ok && (r_state != ST_CLEAR);
  assign w_rd_addr  = (ADDR_SIZE'(r_pix_y) * WIDTH_A) + ADDR_SIZE'(r_pix_x);
  assign w_clr_base = ADDR_SIZE'(r_row) * WIDTH_A;

  // Next-state logic; clear has priority over scan when both arrive in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (clear_start) begin
          w_state_nxt = ST_CLEAR;
        end else if (scan_start) begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_CLEAR: begin
        if (r_row == LAST_Y) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (w_accept && w_eof) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_valid  <= 1'b0;
      r_clear_done <= 1'b0;
      r_busy       <= 1'b0;
      r_wr_drop    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_pix_valid  <= (w_state_nxt == ST_SCAN);
      r_clear_done <= (r_state == ST_CLEAR) && (w_state_nxt == ST_IDLE);
      r_wr_drop    <= write_en && !w_wr_en;

      if ((r_state == ST_CLEAR) && (w_state_nxt == ST_CLEAR)) begin
        r_row <= r_row + Y_W'(1);
      end else begin
        r_row <= '0;
      end

      // Scan coordinates advance only on an accepted beat and park at 0 outside SCAN.
      if (r_state == ST_SCAN) begin
        if (w_accept) begin
          if (w_eol) begin
            r_pix_x <= '0;
            r_pix_y <= w_eof ? '0 : (r_pix_y + Y_W'(1));
          end else begin
            r_pix_x <= r_pix_x + X_W'(1);
          end
        end
      end else begin
        r_pix_x <= '0;
        r_pix_y <= '0;
      end
    end
  end

  // Pixel array: not reset; a clear owns the array for its whole duration.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[w_clr_base +: WIDTH] <= {WIDTH{CLEAR_VAL}};
    end else if (w_wr_en) begin
      r_mem[addr] <= wf_data;
    end
  end

  assign pix_valid  = r_pix_valid;
  // Gated so the output is a clean 0 while idle over uninitialised contents.
  assign pix_data   = r_pix_valid & r_mem[w_rd_addr];
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign pix_eol    = w_eol;
  assign pix_eof    = w_eof;
  assign clear_done = r_clear_done;
  assign busy       = r_busy;
  assign wr_drop    = r_wr_drop;

endmodule

// File: doc/wireframe_fb.md
Name: wireframe_fb

Overview:
Single-bit-per-pixel wireframe frame buffer that sits directly downstream of the rasterizer. It absorbs the rasterizer's pixel write stream (write_en / wf_data / addr) into a WIDTH*HEIGHT bit array. It provides a row-per-cycle frame clear and a raster-order scan-out stream with a valid/ready handshake, feeding the image dump or display path.

Parameters:
WIDTH, 64, pixels per row
HEIGHT, 48, rows per frame
ADDR_SIZE, 12, width of the linear pixel address; must satisfy 2**ADDR_SIZE >= WIDTH*HEIGHT (equals `WIREFRAME_ADDR_SIZE in integration)
CLEAR_VAL, 1, bit written to every pixel by a clear (1 = background)

Ports:
clk  in  1  system clock, all state on rising edge
n_rst  in  1  asynchronous active-low reset
write_en  in  1  rasterizer pixel write strobe
wf_data  in  1  pixel value to write
addr  in  ADDR_SIZE  linear pixel address, y*WIDTH+x
clear_start  in  1  one-cycle request to clear the whole frame
scan_start  in  1  one-cycle request to stream the frame out
pix_ready  in  1  downstream accepts the current pixel
pix_valid  out  1  pix_data/pix_x/pix_y/pix_eol/pix_eof are valid
pix_data  out  1  pixel value at (pix_x, pix_y)
pix_x  out  $clog2(WIDTH)  column of the current scan pixel
pix_y  out  $clog2(HEIGHT)  row of the current scan pixel
pix_eol  out  1  current pixel is the last in its row
pix_eof  out  1  current pixel is the last in the frame
clear_done  out  1  one-cycle pulse when a clear completes
busy  out  1  high in CLEAR or SCAN
wr_drop  out  1  one-cycle pulse: write_en seen but the write was discarded

Behaviour:
- Reset values: all outputs 0, state IDLE, row counter 0, pix_x 0, pix_y 0. Reset does not initialise the pixel array; it holds unknown contents until the first clear.
- Reset asserted mid-CLEAR or mid-SCAN aborts immediately. No clear_done is emitted and there is no final beat.
- State IDLE:
  - clear_start -> CLEAR.
  - Otherwise scan_start -> SCAN.
  - If both are asserted in the same cycle, clear wins and scan_start is lost.
- State CLEAR:
  - Counter r starts at 0. Each cycle, all WIDTH bits of row r are written to CLEAR_VAL and r increments.
  - The cycle row HEIGHT-1 is written, the FSM returns to IDLE and clear_done pulses on the next cycle.
  - clear_start at cycle 0 gives rows cleared in cycles 1..HEIGHT and clear_done high in cycle HEIGHT+1.
- State SCAN:
  - pix_valid is held high.
  - pix_data is a combinational read of mem[pix_y*WIDTH+pix_x].
  - On pix_valid & pix_ready, pix_x increments. When pix_x reaches WIDTH-1 it wraps to 0 and pix_y increments.
  - pix_eol = (pix_x == WIDTH-1). pix_eof = pix_eol & (pix_y == HEIGHT-1).
  - The transfer with pix_eof returns the FSM to IDLE. pix_valid drops next cycle and pix_x/pix_y return to 0.
  - While pix_ready is low, all pixel outputs hold their coordinates. pix_data tracks any write to the presented address on the following cycle.
- clear_start or scan_start while busy is ignored; no queuing.
- Writes:
  - In IDLE or SCAN, write_en with addr < WIDTH*HEIGHT writes wf_data to mem[addr] at the clock edge.
  - Writes during SCAN are allowed. A pixel not yet transferred shows the new value.
  - write_en during CLEAR is discarded, with wr_drop pulsing the next cycle.
  - write_en with addr >= WIDTH*HEIGHT is discarded in any state, with wr_drop pulsing the next cycle.
  - wr_drop is registered and not sticky.
- Width rules:
  - Row index times WIDTH is computed at ADDR_SIZE bits with no truncation for legal parameters.
  - Address comparison is unsigned.

Test Plan:
1. Reset, then clear_start at cycle 0 -> busy in cycles 1..48, clear_done high only in cycle 49. Subsequent full scan with pix_ready=1 returns 3072 ones in 3072 consecutive cycles; pix_eol on every x=63, pix_eof only at (63,47).
2. After a clear, write wf_data=0 to addr 0, 65 and 3071, then scan -> zeros exactly at (0,0), (1,1) and (63,47); wr_drop stays 0.
3. write_en with addr=3072 and with addr=4095 -> wr_drop pulses once each cycle after; scan shows the array unchanged.
4. Start a clear, then write addr 10 with data 0 in cycle 5 -> wr_drop=1 in cycle 6; post-clear scan shows pixel 10 = 1.
5. Scan with pix_ready toggling 1,0,0,1 repeatedly -> each pixel is presented until accepted with stable pix_x/pix_y. While stalled at (5,0), a write of 0 to addr 5 -> pix_data=0 the next cycle. Total 3072 transfers.
6. clear_start and scan_start together in IDLE -> CLEAR runs with no scan afterwards. Asserting n_rst low in cycle 20 of a clear -> busy=0 and clear_done=0 immediately, and no clear_done follows.
